// File: rtl/result_line_packer.sv
// Packs DATA_LEN-bit results popped from the result FIFO into cache lines written to consecutive line addresses.
// Latency: last word popped (fifo_rd_en high at t) -> wr_valid at t+2; one word per two cycles.
// Backpressure: wr_valid/wr_ready handshake; no pops while a line write is waiting for wr_ready.
module result_line_packer #(
    parameter int DATA_LEN  = 32,
    parameter int LINE_BITS = 512,
    parameter int ADDR_BITS = 42,
    localparam int WORDS_PER_LINE = LINE_BITS / DATA_LEN,
    localparam int CNT_BITS = $clog2(WORDS_PER_LINE) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 base_addr_valid,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_LEN-1:0]  fifo_dout,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [LINE_BITS-1:0] wr_data,
    output logic [CNT_BITS-1:0]  wr_word_count,
    output logic [31:0]          lines_written,
    output logic                 busy
);

    localparam int IDX_BITS = (CNT_BITS > 1) ? CNT_BITS - 1 : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_UNCONF  = 2'd0,
        S_COLLECT = 2'd1,
        S_POP     = 2'd2,
        S_ISSUE   = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [CNT_BITS-1:0]  count, count_n;
    logic [ADDR_BITS-1:0] addr, addr_n;
    logic                 flush_pending, flush_n, flush_eff;
    logic                 rd_n, wv_n, accept;
    logic                 cap_pend;
    logic [IDX_BITS-1:0]  cap_idx;

    assign flush_eff     = flush_pending | flush;
    assign wr_addr       = addr;
    assign wr_word_count = count;

    always_comb begin
        state_n = state;
        count_n = count;
        addr_n  = addr;
        flush_n = flush_pending;
        rd_n    = 1'b0;
        wv_n    = wr_valid;
        accept  = 1'b0;
        case (state)
            S_UNCONF: begin
                if (base_addr_valid) begin
                    addr_n  = base_addr;
                    state_n = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (base_addr_valid && count == '0 && !flush_pending)
                    addr_n = base_addr;
                // A same-cycle flush strobe beats a waiting FIFO word
                if (flush_eff && count != '0) begin
                    flush_n = 1'b1;
                    wv_n    = 1'b1;
                    state_n = S_ISSUE;
                end else if (flush_eff) begin
                    flush_n = 1'b0;
                end else if (!fifo_empty) begin
                    rd_n    = 1'b1;
                    state_n = S_POP;
                end
            end
            S_POP: begin
                flush_n = flush_eff;
                count_n = count + CNT_BITS'(1);
                state_n = (count == LAST_CNT) ? S_ISSUE : S_COLLECT;
            end
            S_ISSUE: begin
                flush_n = flush_eff;
                if (!wr_valid) begin
                    wv_n = 1'b1;
                end else if (wr_ready) begin
                    wv_n    = 1'b0;
                    addr_n  = addr + ADDR_BITS'(1);
                    count_n = '0;
                    flush_n = 1'b0;
                    accept  = 1'b1;
                    state_n = S_COLLECT;
                end
            end
            default: state_n = S_UNCONF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_UNCONF;
            count         <= '0;
            addr          <= '0;
            flush_pending <= 1'b0;
            fifo_rd_en    <= 1'b0;
            wr_valid      <= 1'b0;
            wr_data       <= '0;
            lines_written <= '0;
            busy          <= 1'b0;
            cap_pend      <= 1'b0;
            cap_idx       <= '0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            addr          <= addr_n;
            flush_pending <= flush_n;
            fifo_rd_en    <= rd_n;
            wr_valid      <= wv_n;
            busy          <= (count_n != '0) || flush_n ||
                             (state_n == S_POP) || (state_n == S_ISSUE);
            // Read data appears the cycle after the pop, so the slot index is carried one cycle
            cap_pend      <= (state == S_POP);
            if (state == S_POP)
                cap_idx <= count[IDX_BITS-1:0];
            if (accept)
                wr_data <= '0;
            else if (cap_pend)
                wr_data[int'(cap_idx)*DATA_LEN +: DATA_LEN] <= fifo_dout;
            if (accept)
                lines_written <= lines_written + 32'd1;
        end
    end

endmodule
